// File: rtl/dwt_pkg.sv
// Shared definitions for the Haar wavelet decomposition/reconstruction stages.
package dwt_pkg;

    localparam int DWT_W          = 16;
    localparam int DWT_N2         = 256;
    localparam int DWT_FIFO_DEPTH = 4;

    // Serializer phase: which of the four reconstructed samples is emitted next.
    localparam logic [1:0] PH_HI0 = 2'd0;
    localparam logic [1:0] PH_HI1 = 2'd1;
    localparam logic [1:0] PH_LO0 = 2'd2;
    localparam logic [1:0] PH_LO1 = 2'd3;

    typedef struct packed {
        logic signed [DWT_W-1:0] cA;
        logic signed [DWT_W-1:0] cD;
    } coef_pair_t;

endpackage

// File: rtl/dwt_coef_fifo.sv
// First-word-fall-through synchronous FIFO for level-2 coefficient pairs.
module dwt_coef_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dwt_l2_recon.sv
// Level-2 Haar synthesis: each (cA, cD) pair becomes four level-0 samples
// s_hi, s_hi, s_lo, s_lo on a registered valid/ready stream.
module dwt_l2_recon #(
    parameter int W          = dwt_pkg::DWT_W,
    parameter int N2         = dwt_pkg::DWT_N2,
    parameter int FIFO_DEPTH = dwt_pkg::DWT_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] cA_in,
    input  logic [W-1:0] cD_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_done,
    output logic         busy
);

    import dwt_pkg::*;

    localparam logic [8:0] CNT_LAST = 9'(N2 - 1);

    logic           ready_en;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] fifo_rdata;

    logic [1:0]     phase;
    logic           hold_valid;
    logic [W-1:0]   s_hi_q;
    logic [W-1:0]   s_lo_q;
    logic [W-1:0]   s_hi_d;
    logic [W-1:0]   s_lo_d;
    logic           out_last;
    logic [8:0]     pair_cnt;

    logic           out_free;
    logic           out_hs;
    logic           load_out;

    // Ready is held low during reset and rises on the first edge after release.
    assign in_ready  = ready_en && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    assign out_free = !out_valid || out_ready;
    assign out_hs   = out_valid && out_ready;
    assign load_out = hold_valid && out_free;
    // Refill the held pair as its last sample moves into the output register: no bubble.
    assign fifo_pop = !fifo_empty && out_free && (!hold_valid || phase == PH_LO1);

    assign busy = !fifo_empty || hold_valid || out_valid;

    dwt_coef_fifo #(
        .WIDTH (2*W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({cA_in, cD_in}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sign-extended W+1 bit sum/difference cannot overflow; >>>2 floors toward -inf.
    always_comb begin
        logic signed [W:0] a_ext;
        logic signed [W:0] d_ext;
        logic signed [W:0] sum_sh;
        logic signed [W:0] diff_sh;
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        a_ext   = {fifo_rdata[2*W-1], fifo_rdata[2*W-1:W]};
        d_ext   = {fifo_rdata[W-1], fifo_rdata[W-1:0]};
        sum_sh  = (a_ext + d_ext) >>> 2;
        diff_sh = (a_ext - d_ext) >>> 2;
        s_hi_d  = sum_sh[W-1:0];
        s_lo_d  = diff_sh[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            phase      <= PH_HI0;
            hold_valid <= 1'b0;
            s_hi_q     <= '0;
            s_lo_q     <= '0;
        end else begin
            ready_en <= 1'b1;
            if (fifo_pop) begin
                s_hi_q     <= s_hi_d;
                s_lo_q     <= s_lo_d;
                hold_valid <= 1'b1;
            end else if (load_out && phase == PH_LO1) begin
                hold_valid <= 1'b0;
            end
            if (load_out) phase <= phase + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            data_out  <= (phase == PH_HI0 || phase == PH_HI1) ? s_hi_q : s_lo_q;
            out_valid <= 1'b1;
            out_last  <= (phase == PH_LO1);
        end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // A pair counts toward the frame when its fourth sample is taken downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_hs && out_last) begin
                if (pair_cnt == CNT_LAST) begin
                    pair_cnt   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pair_cnt <= pair_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt_l2_recon.sv
// Directed bench for dwt_l2_recon with a 4-pair frame.
module tb_dwt_l2_recon;

    import dwt_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] cA_in = '0;
    logic [W-1:0] cD_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         frame_done;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    dwt_l2_recon #(
        .W          (W),
        .N2         (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cA_in      (cA_in),
        .cD_in      (cD_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One pair into an idle block with out_ready high: exact latency and sample order.
    task automatic push_and_check(input string tag, input int a, input int d, input int hi, input int lo);
        check({tag, "_in_ready"}, in_ready, 1);
        cA_in = W'(a);
        cD_in = W'(d);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        tick();
        check({tag, "_lat2"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_s0"}, $signed(data_out), hi);
        tick();
        check({tag, "_s1"}, $signed(data_out), hi);
        tick();
        check({tag, "_s2"}, $signed(data_out), lo);
        tick();
        check({tag, "_s3"}, $signed(data_out), lo);
        tick();
        check({tag, "_drain"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic push_one(input int a, input int d);
        int n;
        n = 0;
        cA_in = W'(a);
        cD_in = W'(d);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int pushed;
        int hs_cnt;
        int fd_cnt;
        int fd_at;
        int stray;

        // Reset state, asserted asynchronously before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_data", data_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fdone", frame_done, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rel_ready_lo", in_ready, 0);
        tick();
        check("rel_ready_hi", in_ready, 1);

        // Arithmetic: basic, negative, flooring, extremes.
        push_and_check("basic", 100, 20, 30, 20);
        push_and_check("neg", -100, 20, -20, -30);
        push_and_check("pos7", 7, 0, 1, 1);
        push_and_check("neg7", -7, 0, -2, -2);
        push_and_check("max", 32767, 32767, 16383, 0);
        push_and_check("min", -32768, -32768, -16384, 0);
        push_and_check("mix", 32767, -32768, -1, 16383);

        // Backpressure: pair k = (16k+8, 4) gives hi 4k+3, lo 4k+1.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic rdy;
            cA_in = W'(16 * acc + 8);
            cD_in = W'(4);
            rdy = in_ready;
            tick();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_ready_lo", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", $signed(data_out), 3);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int k;
            k = i / 4;
            check("bp_stream_valid", out_valid, 1);
            check("bp_stream_data", $signed(data_out), (i % 4 < 2) ? 4 * k + 3 : 4 * k + 1);
            tick();
        end
        check("bp_drain", out_valid, 0);

        // Frame of 4 pairs, then a fifth pair opening the next frame.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pushed = 0;
        hs_cnt = 0;
        fd_cnt = 0;
        fd_at = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            logic hs;
            logic ac;
            in_valid = (pushed < 5);
            cA_in = W'(16 * pushed + 8);
            cD_in = W'(4);
            hs = out_valid && out_ready;
            ac = in_valid && in_ready;
            tick();
            if (hs) hs_cnt++;
            if (ac) pushed++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = hs_cnt;
            end
        end
        in_valid = 1'b0;
        check("frm_pushed", pushed, 5);
        check("frm_samples", hs_cnt, 20);
        check("frm_pulses", fd_cnt, 1);
        check("frm_pulse_pos", fd_at, 16);

        // Reset while the third sample of a pair is presented, two pairs queued.
        out_ready = 1'b0;
        push_one(40, 8);
        push_one(80, 8);
        push_one(120, 8);
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_phase2", $signed(data_out), 8);
        check("mid_queued", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid || frame_done) stray++;
        end
        check("mid_no_output", stray, 0);
        push_and_check("post_rst", 8, 4, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
